// File: rtl/sprite_plotter.sv
// Rasterises a press or garbage sprite into one of four columns and streams
// (x, y, colour, plot) pixel writes to vga_adapter, one request per handshake.
module sprite_plotter #(
  parameter int         COL_W     = 40,
  parameter int         PRESS_W   = 40,
  parameter int         PRESS_H   = 60,
  parameter int         PRESS_Y   = 0,
  parameter int         GARB_W    = 20,
  parameter int         GARB_H    = 20,
  parameter int         GARB_XOFF = 10,
  parameter int         GARB_Y    = 90,
  parameter logic [2:0] PRESS_COL = 3'b111,
  parameter logic [2:0] GARB_COL  = 3'b010,
  parameter logic [2:0] BG_COL    = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_item,
  input  logic       req_erase,
  input  logic [1:0] req_pos,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLOT,
    S_DONE
  } state_t;

  state_t     r_state;
  logic       r_item;
  logic       r_erase;
  logic [1:0] r_pos;
  logic [5:0] r_xc;
  logic [5:0] r_yc;

  logic       w_last_x;
  logic       w_last_y;
  logic [5:0] w_nxc;
  logic [5:0] w_nyc;
  logic [7:0] w_x0;
  logic [6:0] w_y0;

  function automatic logic [7:0] f_x0(input logic item, input logic [1:0] pos);
    f_x0 = 8'(COL_W * int'(pos)) + (item ? 8'd0 : 8'(GARB_XOFF));
  endfunction

  function automatic logic [6:0] f_y0(input logic item);
    f_y0 = item ? 7'(PRESS_Y) : 7'(GARB_Y);
  endfunction

  function automatic logic [5:0] f_wm1(input logic item);
    f_wm1 = item ? 6'(PRESS_W - 1) : 6'(GARB_W - 1);
  endfunction

  function automatic logic [5:0] f_hm1(input logic item);
    f_hm1 = item ? 6'(PRESS_H - 1) : 6'(GARB_H - 1);
  endfunction

  function automatic logic [2:0] f_col(input logic item, input logic erase);
    f_col = erase ? BG_COL : (item ? PRESS_COL : GARB_COL);
  endfunction

  always_comb begin
    w_last_x = (r_xc == f_wm1(r_item));
    w_last_y = (r_yc == f_hm1(r_item));
    w_nxc    = w_last_x ? '0 : r_xc + 6'd1;
    w_nyc    = w_last_x ? r_yc + 6'd1 : r_yc;
    w_x0     = f_x0(r_item, r_pos);
    w_y0     = f_y0(r_item);
  end

  // Outputs carry the pixel addressed by (r_xc, r_yc); the accept edge already
  // presents pixel (0,0), so each PLOT edge loads the following pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      req_ready <= 1'b1;
      plot      <= 1'b0;
      done      <= 1'b0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      r_xc      <= '0;
      r_yc      <= '0;
      r_item    <= 1'b0;
      r_erase   <= 1'b0;
      r_pos     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_item    <= req_item;
            r_erase   <= req_erase;
            r_pos     <= req_pos;
            r_xc      <= '0;
            r_yc      <= '0;
            x         <= f_x0(req_item, req_pos);
            y         <= f_y0(req_item);
            colour    <= f_col(req_item, req_erase);
            plot      <= 1'b1;
            req_ready <= 1'b0;
            r_state   <= S_PLOT;
          end
        end
        S_PLOT: begin
          if (w_last_x && w_last_y) begin
            plot    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_xc <= w_nxc;
            r_yc <= w_nyc;
            x    <= w_x0 + {2'b00, w_nxc};
            y    <= w_y0 + {1'b0, w_nyc};
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
          plot      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
